// File: rtl/sync_debounce_n.sv
// -----------------------------------------------------------------------------
// sync_debounce_n
//   Multi-channel input conditioner for switches and buttons. Each channel runs
//   through an STAGES-deep synchronizer, a debounce counter that requires the
//   synchronized level to differ from q for DEBOUNCE_CYCLES consecutive cycles
//   before q follows it, and a registered edge detector.
//
//   Optional feature macro: SYNC_DB_TOGGLE_EN
//     When defined, adds the toggle output. Each toggle bit inverts on the clock
//     edge after its rise pulse, which gives push-on/push-off behaviour.
//
// Ports:
//   Clk      in   1      system clock, all flops on posedge
//   Reset_n  in   1      asynchronous active-low reset
//   d        in   WIDTH  raw asynchronous inputs
//   q        out  WIDTH  synchronized, debounced levels
//   rise     out  WIDTH  one-cycle pulse on q 0->1
//   fall     out  WIDTH  one-cycle pulse on q 1->0
//   toggle   out  WIDTH  toggle state (SYNC_DB_TOGGLE_EN only)
// -----------------------------------------------------------------------------
module sync_debounce_n #(
  parameter int                 WIDTH           = 16,
  parameter int                 STAGES          = 2,
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef SYNC_DB_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle
`endif
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] q_q,    q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] s_w;

  // Stage boundary: raw pins -> synchronizer chain
  always_comb begin
    sync_d[0] = d;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s_w = sync_q[STAGES-1];

  // Stage boundary: synchronized level -> debounce counter and q
  // The counter only runs while s differs from q; any return to agreement
  // clears it, so a short excursion never accumulates across glitches.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s_w[i] != q_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          q_d[i] = s_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Stage boundary: q transition -> registered edge pulses
  // Pulses are derived from the next-state of q so they register on the same
  // edge as the q change.
  always_comb begin
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      q_q    <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef SYNC_DB_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q, toggle_d;

  // Stage boundary: rise pulse -> toggle state (changes the cycle after rise)
  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle = toggle_q;
`else
  // Toggle output and its state are not built in this configuration.
`endif

endmodule

// File: tb/tb_sync_debounce_n.sv
module tb_sync_debounce_n;

  localparam int         W   = 4;
  localparam int         STG = 2;
  localparam int         DC  = 4;
  localparam logic [3:0] RV  = 4'b0000;

  logic         Clk     = 1'b0;
  logic         Reset_n = 1'b0;
  logic [W-1:0] d       = 4'hF;
  logic [W-1:0] q, rise, fall;
`ifdef SYNC_DB_TOGGLE_EN
  logic [W-1:0] toggle;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sync_debounce_n #(
    .WIDTH(W), .STAGES(STG), .DEBOUNCE_CYCLES(DC), .RESET_VAL(RV)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .d(d), .q(q), .rise(rise), .fall(fall)
`ifdef SYNC_DB_TOGGLE_EN
    , .toggle(toggle)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the value seen by the debouncer is the pin value
  // sampled STAGES edges earlier; q follows it once it has disagreed with q
  // for DC consecutive edges.
  logic [W-1:0] dq [$];
  logic [W-1:0] q_m, rise_m, fall_m, tog_m, s_seen, q_new;
  int           run_m [W];

  always @(posedge Clk) begin
    if (!Reset_n) begin
      dq = {};
      for (int k = 0; k < STG; k++) dq.push_back(RV);
      q_m = RV; rise_m = '0; fall_m = '0; tog_m = '0;
      for (int c = 0; c < W; c++) run_m[c] = 0;
    end else begin
      s_seen = dq.pop_front();
      dq.push_back(d);
      tog_m = tog_m ^ rise_m;
      q_new = q_m;
      for (int c = 0; c < W; c++) begin
        if (s_seen[c] != q_m[c]) begin
          run_m[c] = run_m[c] + 1;
          if (run_m[c] == DC) begin
            q_new[c] = s_seen[c];
            run_m[c] = 0;
          end
        end else begin
          run_m[c] = 0;
        end
      end
      rise_m = q_new & ~q_m;
      fall_m = ~q_new & q_m;
      q_m    = q_new;
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge Clk) begin
    #2;
    check("model_q", q, q_m);
    check("model_rise", rise, rise_m);
    check("model_fall", fall, fall_m);
    check("rise_and_fall_excl", rise & fall, 4'b0000);
`ifdef SYNC_DB_TOGGLE_EN
    check("model_toggle", toggle, tog_m);
`endif
  end

  task automatic tick();
    @(posedge Clk);
    #4;
  endtask

  task automatic reset_cycle(input logic [W-1:0] dval);
    Reset_n = 1'b0;
    d       = dval;
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    // 1: reset held with all pins high, then release
    repeat (10) begin
      tick();
      check("t1_rst_q", q, 4'h0);
      check("t1_rst_rise", rise, 4'h0);
      check("t1_rst_fall", fall, 4'h0);
    end
    Reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("t1_q_edge5", q, 4'h0);
      if (k == 6) begin
        check("t1_q_edge6", q, 4'hF);
        check("t1_rise_edge6", rise, 4'hF);
      end
      if (k == 7) check("t1_rise_edge7", rise, 4'h0);
    end

    // 2: clean step on channel 0
    reset_cycle(4'b0000);
    d = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("t2_q_edge5", q, 4'b0000);
      if (k == 6) begin
        check("t2_q_edge6", q, 4'b0001);
        check("t2_rise_edge6", rise, 4'b0001);
        check("t2_fall_edge6", fall, 4'b0000);
      end
      if (k == 7) check("t2_rise_edge7", rise, 4'b0000);
    end

    // 3: 3-cycle glitch on channel 1 is rejected, then a real step
    d = 4'b0011;
    repeat (3) tick();
    d = 4'b0001;
    repeat (8) begin
      tick();
      check("t3_glitch_q", q, 4'b0001);
      check("t3_glitch_rise", rise, 4'b0000);
    end
    d = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("t3_q_edge5", q, 4'b0001);
      if (k == 6) begin
        check("t3_q_edge6", q, 4'b0011);
        check("t3_rise_edge6", rise, 4'b0010);
      end
    end

    // 4: simultaneous rise on ch2 and fall on ch3
    d = 4'b1011;
    repeat (8) tick();
    check("t4_setup_q", q, 4'b1011);
    d = 4'b0111;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("t4_q_edge5", q, 4'b1011);
      if (k == 6) begin
        check("t4_q_edge6", q, 4'b0111);
        check("t4_rise_edge6", rise, 4'b0100);
        check("t4_fall_edge6", fall, 4'b1000);
      end
      if (k == 7) begin
        check("t4_rise_edge7", rise, 4'b0000);
        check("t4_fall_edge7", fall, 4'b0000);
      end
    end

    // 5: reset mid-debounce discards the partial count
    reset_cycle(4'b0000);
    d = 4'b0001;
    repeat (4) tick();
    Reset_n = 1'b0;
    repeat (2) begin
      tick();
      check("t5_rst_q", q, 4'b0000);
      check("t5_rst_rise", rise, 4'b0000);
    end
    Reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check("t5_q_edge5", q, 4'b0000);
      if (k == 6) begin
        check("t5_q_edge6", q, 4'b0001);
        check("t5_rise_edge6", rise, 4'b0001);
      end
    end

`ifdef SYNC_DB_TOGGLE_EN
    // 6: three presses on channel 0 toggle 1, 0, 1
    reset_cycle(4'b0000);
    check("t6_toggle_init", toggle, 4'b0000);
    for (int p = 0; p < 3; p++) begin
      d = 4'b0001;
      repeat (6) tick();
      check("t6_rise", rise, 4'b0001);
      check("t6_toggle_before", toggle, (p % 2 == 0) ? 4'b0000 : 4'b0001);
      tick();
      check("t6_toggle_after", toggle, (p % 2 == 0) ? 4'b0001 : 4'b0000);
      d = 4'b0000;
      repeat (10) tick();
    end
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
